// File: rtl/bf2_bundle_packer.sv
// Serial-to-parallel packer: gathers DEPTH complex samples into one lane bundle for the
// radix-2 butterfly, double-buffered so one bundle can be held while the next one fills.
module bf2_bundle_packer #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [WIDTH-1:0]         s_r,
   input  logic [WIDTH-1:0]         s_q,
   input  logic                     s_last,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DEPTH*WIDTH-1:0]   dout_R,
   output logic [DEPTH*WIDTH-1:0]   dout_Q,
   output logic                     m_last
);

   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = DEPTH * WIDTH;

   typedef enum logic {FILL, HOLD} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   buf_r_q, buf_r_d, buf_q_q, buf_q_d;
   logic [BW-1:0]   out_r_q, out_r_d, out_q_q, out_q_d;
   logic            m_valid_q, m_valid_d;
   logic            m_last_q, m_last_d;
   logic            hold_last_q, hold_last_d;
   logic [BW-1:0]   merged_r, merged_q;
   logic            accept, close, slot_free;

   assign s_ready   = (state_q == FILL) & ~rst;
   assign accept    = s_valid & s_ready;
   assign close     = accept & ((cnt_q == CW'(DEPTH - 1)) | s_last);
   assign slot_free = ~m_valid_q | m_ready;

   // Fill buffer with the incoming sample dropped into lane cnt.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
      assign merged_r[gi*WIDTH +: WIDTH] = (cnt_q == CW'(gi)) ? s_r : buf_r_q[gi*WIDTH +: WIDTH];
      assign merged_q[gi*WIDTH +: WIDTH] = (cnt_q == CW'(gi)) ? s_q : buf_q_q[gi*WIDTH +: WIDTH];
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      buf_r_d     = buf_r_q;
      buf_q_d     = buf_q_q;
      out_r_d     = out_r_q;
      out_q_d     = out_q_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      hold_last_d = hold_last_q;
      case (state_q)
         FILL: begin
            if (close) begin
               cnt_d = '0;
               if (slot_free) begin
                  // Replaces any bundle consumed this cycle, so no bubble on m_valid.
                  out_r_d   = merged_r;
                  out_q_d   = merged_q;
                  m_valid_d = 1'b1;
                  m_last_d  = s_last;
                  buf_r_d   = '0;
                  buf_q_d   = '0;
               end else begin
                  buf_r_d     = merged_r;
                  buf_q_d     = merged_q;
                  hold_last_d = s_last;
                  state_d     = HOLD;
               end
            end else begin
               if (accept) begin
                  buf_r_d = merged_r;
                  buf_q_d = merged_q;
                  cnt_d   = cnt_q + 1'b1;
               end
               if (m_valid_q & m_ready) begin
                  m_valid_d = 1'b0;
               end
            end
         end
         HOLD: begin
            if (m_ready) begin
               out_r_d   = buf_r_q;
               out_q_d   = buf_q_q;
               m_valid_d = 1'b1;
               m_last_d  = hold_last_q;
               buf_r_d   = '0;
               buf_q_d   = '0;
               cnt_d     = '0;
               state_d   = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         buf_r_q     <= '0;
         buf_q_q     <= '0;
         out_r_q     <= '0;
         out_q_q     <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         hold_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         buf_r_q     <= buf_r_d;
         buf_q_q     <= buf_q_d;
         out_r_q     <= out_r_d;
         out_q_q     <= out_q_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         hold_last_q <= hold_last_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign dout_R  = out_r_q;
   assign dout_Q  = out_q_q;

endmodule

// File: tb/tb_bf2_bundle_packer.sv
// Bench for bf2_bundle_packer: directed scenarios plus randomized traffic checked against
// a queue-based model that chops the accepted sample stream into bundles.
module tb_bf2_bundle_packer;

   localparam int W  = 9;
   localparam int D  = 16;
   localparam int BW = W * D;

   logic          clk = 1'b0;
   logic          rst, s_valid, s_ready, s_last, m_valid, m_ready, m_last;
   logic [W-1:0]  s_r, s_q;
   logic [BW-1:0] dout_R, dout_Q;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   bf2_bundle_packer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_q(s_q),
      .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .dout_R(dout_R),
      .dout_Q(dout_Q), .m_last(m_last)
   );

   always #5 clk = ~clk;

   // Reference model: accepted samples collect in a list; a full list or s_last emits a bundle.
   logic [W-1:0]  cur_r [D];
   logic [W-1:0]  cur_q [D];
   int            cur_n = 0;
   logic [BW-1:0] exp_r_fifo [$];
   logic [BW-1:0] exp_q_fifo [$];
   bit            exp_l_fifo [$];

   task automatic model_reset();
      cur_n = 0;
      exp_r_fifo.delete();
      exp_q_fifo.delete();
      exp_l_fifo.delete();
   endtask

   task automatic model_push(input logic [W-1:0] r, input logic [W-1:0] q, input bit last);
      logic [BW-1:0] br, bq;
      cur_r[cur_n] = r;
      cur_q[cur_n] = q;
      cur_n++;
      if (cur_n == D || last) begin
         br = '0;
         bq = '0;
         for (int i = 0; i < cur_n; i++) begin
            br[i*W +: W] = cur_r[i];
            bq[i*W +: W] = cur_q[i];
         end
         exp_r_fifo.push_back(br);
         exp_q_fifo.push_back(bq);
         exp_l_fifo.push_back(last);
         cur_n = 0;
      end
   endtask

   function automatic logic signed [W-1:0] lane(input logic [BW-1:0] v, input int k);
      return v[k*W +: W];
   endfunction

   // One clock: drive inputs just after the edge, sample just after that, update the model.
   task automatic drive_cycle(input bit rv, input bit v, input logic [W-1:0] r, input logic [W-1:0] q,
                              input bit l, input bit mr, output bit cons, output bit have,
                              output logic [BW-1:0] er, output logic [BW-1:0] eq, output bit el);
      @(posedge clk);
      #1;
      rst = rv; s_valid = v; s_r = r; s_q = q; s_last = l; m_ready = mr;
      #1;
      cons = m_valid & m_ready & ~rst;
      have = 1'b0; er = '0; eq = '0; el = 1'b0;
      if (cons) begin
         $display("bundle out: R=%h Q=%h last=%0b", dout_R, dout_Q, m_last);
         if (exp_r_fifo.size() > 0) begin
            have = 1'b1;
            er = exp_r_fifo.pop_front();
            eq = exp_q_fifo.pop_front();
            el = exp_l_fifo.pop_front();
         end
      end
      if (rst) model_reset();
      else if (s_valid & s_ready) model_push(r, q, l);
   endtask

   task automatic test_reset();
      bit cons, have, el; logic [BW-1:0] er, eq;
      for (int c = 0; c < 2; c++) begin
         drive_cycle(1, 0, '0, '0, 0, 0, cons, have, er, eq, el);
         chk_cnt++;
         if (s_ready !== 1'b0 || m_valid !== 1'b0 || dout_R !== '0 || dout_Q !== '0 || m_last !== 1'b0)
            $display("FAIL reset_hold: s_ready=%b m_valid=%b m_last=%b R=%h Q=%h, need all 0", s_ready, m_valid, m_last, dout_R, dout_Q);
         else pass_cnt++;
      end
      drive_cycle(0, 0, '0, '0, 0, 0, cons, have, er, eq, el);
      chk_cnt++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0)
         $display("FAIL reset_release: s_ready=%b m_valid=%b, need 1 0", s_ready, m_valid);
      else pass_cnt++;
   endtask

   task automatic test_full_bundle();
      bit cons, have, el; logic [BW-1:0] er, eq, xr, xq; int gaps = 0;
      for (int k = 0; k < D; k++) begin
         drive_cycle(0, 1, W'(k + 1), W'(-(k + 1)), 0, 1, cons, have, er, eq, el);
         if (s_ready !== 1'b1) gaps++;
         xr[k*W +: W] = W'(k + 1);
         xq[k*W +: W] = W'(-(k + 1));
      end
      chk_cnt++;
      if (gaps != 0) $display("FAIL full_ready_gaps: %0d gaps, need 0", gaps); else pass_cnt++;
      drive_cycle(0, 0, '0, '0, 0, 1, cons, have, er, eq, el);
      chk_cnt++;
      if (m_valid !== 1'b1 || dout_R !== xr || dout_Q !== xq || m_last !== 1'b0)
         $display("FAIL full_bundle: m_valid=%b last=%b R=%h Q=%h, need 1 0 R=%h Q=%h", m_valid, m_last, dout_R, dout_Q, xr, xq);
      else pass_cnt++;
      chk_cnt++;
      if (!have || dout_R !== er || dout_Q !== eq || m_last !== el)
         $display("FAIL full_model: have=%b R=%h Q=%h last=%b, need R=%h Q=%h last=%b", have, dout_R, dout_Q, m_last, er, eq, el);
      else pass_cnt++;
      drive_cycle(0, 0, '0, '0, 0, 1, cons, have, er, eq, el);
      chk_cnt++;
      if (m_valid !== 1'b0) $display("FAIL full_one_cycle: m_valid=%b, need 0", m_valid); else pass_cnt++;
   endtask

   task automatic test_partial();
      bit cons, have, el; logic [BW-1:0] er, eq, xr, xq;
      xr = '0; xq = '0;
      for (int k = 0; k < 5; k++) begin
         drive_cycle(0, 1, W'(2 * (k + 1)), W'(3 * (k + 1)), k == 4, 1, cons, have, er, eq, el);
         xr[k*W +: W] = W'(2 * (k + 1));
         xq[k*W +: W] = W'(3 * (k + 1));
      end
      drive_cycle(0, 0, '0, '0, 0, 1, cons, have, er, eq, el);
      chk_cnt++;
      if (m_valid !== 1'b1 || dout_R !== xr || dout_Q !== xq || m_last !== 1'b1)
         $display("FAIL partial_bundle: m_valid=%b last=%b R=%h Q=%h, need 1 1 R=%h Q=%h", m_valid, m_last, dout_R, dout_Q, xr, xq);
      else pass_cnt++;
      chk_cnt++;
      if (!have || dout_R !== er || dout_Q !== eq || m_last !== el)
         $display("FAIL partial_model: have=%b R=%h last=%b, need R=%h last=%b", have, dout_R, m_last, er, el);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      bit cons, have, el; logic [BW-1:0] er, eq, ar, aq, br, bq; int gaps = 0;
      for (int k = 0; k < 2 * D; k++) begin
         drive_cycle(0, 1, W'(10 + k), W'(-k), 0, 0, cons, have, er, eq, el);
         if (s_ready !== 1'b1) gaps++;
         if (k < D) begin ar[k*W +: W] = W'(10 + k); aq[k*W +: W] = W'(-k); end
         else begin br[(k-D)*W +: W] = W'(10 + k); bq[(k-D)*W +: W] = W'(-k); end
      end
      chk_cnt++;
      if (gaps != 0) $display("FAIL bp_ready_gaps: %0d gaps, need 0", gaps); else pass_cnt++;
      for (int c = 0; c < 2; c++) begin
         drive_cycle(0, 0, '0, '0, 0, 0, cons, have, er, eq, el);
         chk_cnt++;
         if (s_ready !== 1'b0 || m_valid !== 1'b1 || dout_R !== ar || dout_Q !== aq || m_last !== 1'b0)
            $display("FAIL bp_hold_A: s_ready=%b m_valid=%b R=%h, need 0 1 R=%h", s_ready, m_valid, dout_R, ar);
         else pass_cnt++;
      end
      drive_cycle(0, 0, '0, '0, 0, 1, cons, have, er, eq, el);
      chk_cnt++;
      if (!have || dout_R !== er || dout_Q !== eq || m_last !== el)
         $display("FAIL bp_model_A: have=%b R=%h, need R=%h", have, dout_R, er);
      else pass_cnt++;
      drive_cycle(0, 0, '0, '0, 0, 0, cons, have, er, eq, el);
      chk_cnt++;
      if (s_ready !== 1'b1 || m_valid !== 1'b1 || dout_R !== br || dout_Q !== bq)
         $display("FAIL bp_show_B: s_ready=%b m_valid=%b R=%h Q=%h, need 1 1 R=%h Q=%h", s_ready, m_valid, dout_R, dout_Q, br, bq);
      else pass_cnt++;
      drive_cycle(0, 0, '0, '0, 0, 1, cons, have, er, eq, el);
      chk_cnt++;
      if (!have || dout_R !== er || dout_Q !== eq || m_last !== el)
         $display("FAIL bp_model_B: have=%b R=%h, need R=%h", have, dout_R, er);
      else pass_cnt++;
   endtask

   task automatic test_boundaries();
      bit cons, have, el; logic [BW-1:0] er, eq, xr, xq;
      int rv[4] = '{255, -256, 255, -256};
      int qv[4] = '{-256, 255, 0, -1};
      xr = '0; xq = '0;
      for (int k = 0; k < 4; k++) begin
         drive_cycle(0, 1, W'(rv[k]), W'(qv[k]), k == 3, 1, cons, have, er, eq, el);
         xr[k*W +: W] = W'(rv[k]);
         xq[k*W +: W] = W'(qv[k]);
      end
      drive_cycle(0, 0, '0, '0, 0, 1, cons, have, er, eq, el);
      chk_cnt++;
      if (m_valid !== 1'b1 || dout_R !== xr || dout_Q !== xq)
         $display("FAIL bound_bundle: m_valid=%b R=%h Q=%h, need 1 R=%h Q=%h", m_valid, dout_R, dout_Q, xr, xq);
      else pass_cnt++;
      chk_cnt++;
      if (int'(lane(dout_R, 1)) != -256 || int'(lane(dout_Q, 3)) != -1)
         $display("FAIL bound_sign: R1=%0d Q3=%0d, need -256 -1", lane(dout_R, 1), lane(dout_Q, 3));
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      bit cons, have, el; logic [BW-1:0] er, eq, xr, xq;
      for (int k = 0; k < 7; k++)
         drive_cycle(0, 1, W'(50 + k), W'(k + 1), 0, 1, cons, have, er, eq, el);
      drive_cycle(1, 0, '0, '0, 0, 1, cons, have, er, eq, el);
      for (int k = 0; k < D; k++) begin
         drive_cycle(0, 1, W'(100 + k), W'(k), 0, 1, cons, have, er, eq, el);
         xr[k*W +: W] = W'(100 + k);
         xq[k*W +: W] = W'(k);
      end
      drive_cycle(0, 0, '0, '0, 0, 1, cons, have, er, eq, el);
      chk_cnt++;
      if (m_valid !== 1'b1 || dout_R !== xr || dout_Q !== xq || m_last !== 1'b0)
         $display("FAIL rstmid_bundle: m_valid=%b R=%h Q=%h, need 1 R=%h Q=%h", m_valid, dout_R, dout_Q, xr, xq);
      else pass_cnt++;
      drive_cycle(0, 0, '0, '0, 0, 1, cons, have, er, eq, el);
      chk_cnt++;
      if (m_valid !== 1'b0) $display("FAIL rstmid_extra: m_valid=%b, need 0", m_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bit cons, have, el; logic [BW-1:0] er, eq; int bubbles = 0, bad = 0;
      for (int k = 0; k < 7; k++) begin
         drive_cycle(0, k < 6, W'($urandom), W'($urandom), 1, 1, cons, have, er, eq, el);
         if (k >= 1 && m_valid !== 1'b1) bubbles++;
         if (cons && (!have || dout_R !== er || dout_Q !== eq || m_last !== el)) bad++;
      end
      chk_cnt++;
      if (bubbles != 0) $display("FAIL b2b_bubbles: %0d bubbles, need 0", bubbles); else pass_cnt++;
      chk_cnt++;
      if (bad != 0) $display("FAIL b2b_model: %0d wrong bundles, need 0", bad); else pass_cnt++;
   endtask

   task automatic test_random();
      bit cons, have, el, prev_hold = 0, prev_l = 0; logic [BW-1:0] er, eq, prev_r = '0, prev_q = '0;
      for (int c = 0; c < 800; c++) begin
         drive_cycle(0, $urandom_range(0, 9) < 7, W'($urandom), W'($urandom), $urandom_range(0, 9) == 0,
                     $urandom_range(0, 9) < 6, cons, have, er, eq, el);
         if (prev_hold) begin
            chk_cnt++;
            if (m_valid !== 1'b1 || dout_R !== prev_r || dout_Q !== prev_q || m_last !== prev_l)
               $display("FAIL rand_stable: m_valid=%b R=%h last=%b, need 1 R=%h last=%b", m_valid, dout_R, m_last, prev_r, prev_l);
            else pass_cnt++;
         end
         if (cons) begin
            chk_cnt++;
            if (!have || dout_R !== er || dout_Q !== eq || m_last !== el)
               $display("FAIL rand_bundle: have=%b R=%h Q=%h last=%b, need R=%h Q=%h last=%b", have, dout_R, dout_Q, m_last, er, eq, el);
            else pass_cnt++;
         end
         prev_hold = m_valid & ~m_ready;
         prev_r = dout_R; prev_q = dout_Q; prev_l = m_last;
      end
      for (int c = 0; c < 4; c++) begin
         drive_cycle(0, 0, '0, '0, 0, 1, cons, have, er, eq, el);
         if (cons) begin
            chk_cnt++;
            if (!have || dout_R !== er || dout_Q !== eq || m_last !== el)
               $display("FAIL drain_bundle: have=%b R=%h, need R=%h", have, dout_R, er);
            else pass_cnt++;
         end
      end
      chk_cnt++;
      if (exp_r_fifo.size() != 0 || m_valid !== 1'b0)
         $display("FAIL drain_empty: %0d bundles left, m_valid=%b, need 0 0", exp_r_fifo.size(), m_valid);
      else pass_cnt++;
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_r = '0; s_q = '0; s_last = 1'b0; m_ready = 1'b0;
      test_reset();
      test_full_bundle();
      test_partial();
      test_backpressure();
      test_boundaries();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
